// File: rtl/imem_loader_pkg.sv
// Loader definitions shared with the debug unit.
// Holds the FSM state encodings, the default end-of-program marker and small helpers.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

  localparam logic [31:0] LOADER_HALT_WORD = 32'hFFFF_FFFF;
  localparam int          BYTE_W           = 8;

  // Bytes are only taken while a word is being collected or written.
  function automatic logic is_busy_state(input loader_state_t s);
    return (s == ST_RECV) || (s == ST_WRITE);
  endfunction

  function automatic logic is_idle_state(input loader_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Big-endian byte-to-word assembler: shifts accepted bytes in MSB first and
// flags the cycle in which the final byte of a word arrives.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int NB_WORD = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_en,
  input  logic [BYTE_W-1:0]  i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_WORD-1:0] o_word,
  output logic               o_word_valid
);

  localparam int N_BYTES = NB_WORD / BYTE_W;
  localparam int NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [NB_WORD-BYTE_W-1:0] r_shift;
  logic [NB_IDX-1:0]         r_idx;
  logic                      w_accept;
  logic                      w_last;

  assign w_accept     = i_en && i_rx_valid;
  assign w_last       = (r_idx == NB_IDX'(N_BYTES - 1));
  // The completed word includes the byte arriving this cycle.
  assign o_word       = {r_shift, i_rx_data};
  assign o_word_valid = w_accept && w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_shift <= o_word[NB_WORD-BYTE_W-1:0];
      r_idx   <= w_last ? '0 : r_idx + NB_IDX'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles received bytes into words and writes
// them to consecutive addresses until the halt word or memory end is reached.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                     NB_DATA_BUS = 32,
  parameter int                     N_ADDRESS   = 64,
  parameter int                     NB_ADDRESS  = $clog2(N_ADDRESS),
  parameter logic [NB_DATA_BUS-1:0] HALT_WORD   = LOADER_HALT_WORD
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_w_en,
  output logic [NB_ADDRESS-1:0]  o_w_addr,
  output logic [NB_DATA_BUS-1:0] o_w_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [NB_ADDRESS:0]    o_word_count
);

  loader_state_t          r_state;
  logic                   r_w_en;
  logic [NB_ADDRESS-1:0]  r_addr;
  logic [NB_DATA_BUS-1:0] r_w_data;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic [NB_ADDRESS:0]    r_count;

  logic                   w_start_ok;
  logic                   w_asm_en;
  logic [NB_DATA_BUS-1:0] w_word;
  logic                   w_word_valid;

  assign w_start_ok = i_start && is_idle_state(r_state);
  // The WRITE cycle keeps the assembler open so a byte arriving then is not lost.
  assign w_asm_en   = is_busy_state(r_state);

  imem_loader_byte_assembler #(
    .NB_WORD (NB_DATA_BUS)
  ) u_byte_assembler (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_start_ok),
    .i_en         (w_asm_en),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_w_en   <= 1'b0;
      r_addr   <= '0;
      r_w_data <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            r_state <= ST_RECV;
            r_addr  <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        ST_RECV: begin
          if (w_word_valid) begin
            r_state  <= ST_WRITE;
            r_w_en   <= 1'b1;
            r_w_data <= w_word;
          end
        end
        ST_WRITE: begin
          r_w_en  <= 1'b0;
          r_count <= r_count + 1'b1;
          if (r_w_data == HALT_WORD) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_addr == NB_ADDRESS'(N_ADDRESS - 1)) begin
            // Last address used without a halt word: stop rather than wrap.
            r_state <= ST_ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_state <= ST_RECV;
            r_addr  <= r_addr + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_w_en  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_w_en       = r_w_en;
  assign o_w_addr     = r_addr;
  assign o_w_data     = r_w_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_word_count = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: every memory write is logged
// on the falling edge and compared against hand-computed expectations.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        w_en;
  logic [5:0]  w_addr;
  logic [31:0] w_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [6:0]  word_count;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          wr_n = 0;
  int          base;
  logic [5:0]  wr_addr [0:255];
  logic [31:0] wr_data [0:255];

  imem_loader dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_w_en       (w_en),
    .o_w_addr     (w_addr),
    .o_w_data     (w_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      if (wr_n < 256) begin
        wr_addr[wr_n] = w_addr;
        wr_data[wr_n] = w_data;
      end
      wr_n = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends n bytes back to back, most significant first; returns one negedge
  // after the last byte was sampled, with the strobe dropped.
  task automatic send_bytes(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_data  = bytes[8*(n-1-i) +: 8];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_w_en",  64'(w_en), 64'd0);
    check("rst_w_addr", 64'(w_addr), 64'd0);
    check("rst_w_data", 64'(w_data), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    rst = 1'b0;
    settle();

    // Bytes in IDLE are ignored
    send_bytes(64'h12345678, 4);
    settle();
    check("idle_no_write", 64'(wr_n), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Basic program: one word then halt
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_count", 64'(word_count), 64'd0);
    send_bytes(64'h12345678, 4);
    check("write0_en", 64'(w_en), 64'd1);
    check("write0_addr", 64'(w_addr), 64'd0);
    check("write0_data", 64'(w_data), 64'h12345678);
    send_bytes(64'hFFFFFFFF, 4);
    settle();
    check("prog1_nwrites", 64'(wr_n), 64'd2);
    check("prog1_w0_addr", 64'(wr_addr[0]), 64'd0);
    check("prog1_w0_data", 64'(wr_data[0]), 64'h12345678);
    check("prog1_w1_addr", 64'(wr_addr[1]), 64'd1);
    check("prog1_w1_data", 64'(wr_data[1]), 64'hFFFFFFFF);
    check("prog1_done", 64'(done), 64'd1);
    check("prog1_busy", 64'(busy), 64'd0);
    check("prog1_count", 64'(word_count), 64'd2);
    check("prog1_hold_data", 64'(w_data), 64'hFFFFFFFF);

    // Bytes in DONE are ignored
    base = wr_n;
    send_bytes(64'h01020304, 4);
    settle();
    check("done_no_write", 64'(wr_n - base), 64'd0);
    check("done_sticky", 64'(done), 64'd1);

    // Restart, start during RECV ignored, byte during WRITE kept
    pulse_start();
    check("restart_done", 64'(done), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_count", 64'(word_count), 64'd0);
    base = wr_n;
    send_bytes(64'hDEAD, 2);
    pulse_start();
    check("recv_start_addr", 64'(w_addr), 64'd0);
    check("recv_start_count", 64'(word_count), 64'd0);
    check("recv_start_busy", 64'(busy), 64'd1);
    send_bytes(64'hBEEFFFFFFFFF, 6);
    settle();
    check("prog2_nwrites", 64'(wr_n - base), 64'd2);
    check("prog2_w0_addr", 64'(wr_addr[base]), 64'd0);
    check("prog2_w0_data", 64'(wr_data[base]), 64'hDEADBEEF);
    check("prog2_w1_addr", 64'(wr_addr[base+1]), 64'd1);
    check("prog2_w1_data", 64'(wr_data[base+1]), 64'hFFFFFFFF);
    check("prog2_done", 64'(done), 64'd1);
    check("prog2_count", 64'(word_count), 64'd2);

    // Reset during WRITE drops the strobe without a clock edge
    pulse_start();
    send_bytes(64'h11223344, 4);
    check("pre_rst_w_en", 64'(w_en), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_w_en", 64'(w_en), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    #1;
    rst = 1'b0;

    // Partial word discarded by reset
    pulse_start();
    send_bytes(64'hAABB, 2);
    pulse_reset();
    check("partial_rst_busy", 64'(busy), 64'd0);
    check("partial_rst_count", 64'(word_count), 64'd0);
    base = wr_n;
    pulse_start();
    send_bytes(64'h01020304, 4);
    settle();
    check("partial_nwrites", 64'(wr_n - base), 64'd1);
    check("partial_w_addr", 64'(wr_addr[base]), 64'd0);
    check("partial_w_data", 64'(wr_data[base]), 64'h01020304);
    check("partial_count", 64'(word_count), 64'd1);
    check("partial_busy", 64'(busy), 64'd1);

    // Fill memory without a halt word
    pulse_reset();
    base = wr_n;
    pulse_start();
    for (int i = 0; i < 64; i++) send_bytes(64'h00000001, 4);
    settle();
    check("fill_nwrites", 64'(wr_n - base), 64'd64);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("fill_addr%0d", i), 64'(wr_addr[base+i]), 64'(i));
      check($sformatf("fill_data%0d", i), 64'(wr_data[base+i]), 64'd1);
    end
    check("fill_error", 64'(error), 64'd1);
    check("fill_done", 64'(done), 64'd0);
    check("fill_busy", 64'(busy), 64'd0);
    check("fill_count", 64'(word_count), 64'd64);
    send_bytes(64'h00000001, 4);
    settle();
    check("fill_no_write64", 64'(wr_n - base), 64'd64);
    check("fill_error_sticky", 64'(error), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
